// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 note decoder.
//   - decoder FSM state enumeration
//   - PS/2 prefix bytes (E0 extended, F0 break)
//   - the seven note scancodes, the four arrow scancodes
//   - note_held bit index for each note (A = bit 6 ... G = bit 0)
//   - note_lookup(): scancode -> {hit, bit index}
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  localparam logic [7:0] CODE_NOTE_A = 8'h16;
  localparam logic [7:0] CODE_NOTE_B = 8'h1E;
  localparam logic [7:0] CODE_NOTE_C = 8'h26;
  localparam logic [7:0] CODE_NOTE_D = 8'h25;
  localparam logic [7:0] CODE_NOTE_E = 8'h2E;
  localparam logic [7:0] CODE_NOTE_F = 8'h36;
  localparam logic [7:0] CODE_NOTE_G = 8'h3D;

  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  localparam logic [2:0] NOTE_A_BIT = 3'd6;
  localparam logic [2:0] NOTE_B_BIT = 3'd5;
  localparam logic [2:0] NOTE_C_BIT = 3'd4;
  localparam logic [2:0] NOTE_D_BIT = 3'd3;
  localparam logic [2:0] NOTE_E_BIT = 3'd2;
  localparam logic [2:0] NOTE_F_BIT = 3'd1;
  localparam logic [2:0] NOTE_G_BIT = 3'd0;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } note_map_t;

  function automatic note_map_t note_lookup(input logic [7:0] code);
    note_map_t m;
    m.hit = 1'b1;
    m.idx = 3'd0;
    case (code)
      CODE_NOTE_A: m.idx = NOTE_A_BIT;
      CODE_NOTE_B: m.idx = NOTE_B_BIT;
      CODE_NOTE_C: m.idx = NOTE_C_BIT;
      CODE_NOTE_D: m.idx = NOTE_D_BIT;
      CODE_NOTE_E: m.idx = NOTE_E_BIT;
      CODE_NOTE_F: m.idx = NOTE_F_BIT;
      CODE_NOTE_G: m.idx = NOTE_G_BIT;
      default:     m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: assembles PS/2 bytes into key events (E0/F0 prefixes)
// and tracks a small musical keyboard state from them.
//
// Ports:
//   CLOCK_50   in   clock for all logic
//   resetn     in   asynchronous active-low reset
//   byte_data  in   [7:0] byte from the PS/2 receiver
//   byte_en    in   one-cycle strobe qualifying byte_data
//   key_valid  out  one-cycle pulse per completed key event
//   key_code   out  [7:0] final scancode of the last event
//   key_ext    out  last event carried an E0 prefix
//   key_break  out  last event was a release (F0 prefix)
//   note_held  out  [6:0] A..G held (bit 6 = A, bit 0 = G)
//   octave     out  [3:0] signed octave offset, OCT_MIN..OCT_MAX
//   flat       out  left arrow held
//   sharp      out  right arrow held
//
// Build option: define PS2_TYPEMATIC_FILTER_EN to drop typematic repeats
// (no key_valid for a repeated note make, one octave step per arrow press).
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | both E0 and F0 seen
module ps2_note_decoder
  import ps2_pkg::*;
#(
  parameter int OCT_MIN     = -4,
  parameter int OCT_MAX     = 4,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] byte_data,
  input  logic       byte_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [6:0] note_held,
  output logic [3:0] octave,
  output logic       flat,
  output logic       sharp
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic signed [3:0] OCT_HI = 4'(OCT_MAX);
  localparam logic signed [3:0] OCT_LO = 4'(OCT_MIN);

  ps2_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic               r_key_valid, r_key_ext, r_key_break;
  logic [7:0]         r_key_code;
  logic [6:0]         r_notes;
  logic signed [3:0]  r_octave;
  logic               r_flat, r_sharp;

  logic      w_event, w_ext, w_brk, w_timeout;
  note_map_t w_note;
  logic      w_note_upd, w_arrow, w_suppress, w_up_step, w_dn_step;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A byte_en always wins over a timeout landing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_event     = 1'b0;
    w_timeout   = 1'b0;
    w_ext       = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    w_brk       = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    if (byte_en) begin
      if (byte_data == CODE_E0) begin
        case (r_state)
          ST_IDLE: w_state_nxt = ST_EXT;
          ST_BRK:  w_state_nxt = ST_EXT_BRK;
          default: w_state_nxt = r_state;
        endcase
      end else if (byte_data == CODE_F0) begin
        case (r_state)
          ST_IDLE: w_state_nxt = ST_BRK;
          ST_EXT:  w_state_nxt = ST_EXT_BRK;
          default: w_state_nxt = r_state;
        endcase
      end else begin
        w_event     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    end else if ((r_state != ST_IDLE) && (r_idle_cnt == CNT_TC)) begin
      w_timeout   = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  assign w_note     = note_lookup(byte_data);
  assign w_note_upd = w_event && !w_ext && w_note.hit;
  assign w_arrow    = w_event && w_ext;

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Latches remember an arrow is down so repeats do not keep stepping.
  logic r_up_latch, r_dn_latch;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_up_latch <= 1'b0;
      r_dn_latch <= 1'b0;
    end else if (w_arrow) begin
      if (byte_data == CODE_UP)   r_up_latch <= !w_brk;
      if (byte_data == CODE_DOWN) r_dn_latch <= !w_brk;
    end
  end

  assign w_suppress = w_note_upd && !w_brk && r_notes[w_note.idx];
  assign w_up_step  = w_arrow && !w_brk && (byte_data == CODE_UP)   && !r_up_latch;
  assign w_dn_step  = w_arrow && !w_brk && (byte_data == CODE_DOWN) && !r_dn_latch;
`else
  assign w_suppress = 1'b0;
  assign w_up_step  = w_arrow && !w_brk && (byte_data == CODE_UP);
  assign w_dn_step  = w_arrow && !w_brk && (byte_data == CODE_DOWN);
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_idle_cnt  <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_notes     <= 7'd0;
      r_octave    <= 4'sd0;
      r_flat      <= 1'b0;
      r_sharp     <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;

      if (byte_en || w_timeout || (r_state == ST_IDLE)) r_idle_cnt <= '0;
      else                                               r_idle_cnt <= r_idle_cnt + CNT_W'(1);

      if (w_event) begin
        r_key_valid <= !w_suppress;
        r_key_code  <= byte_data;
        r_key_ext   <= w_ext;
        r_key_break <= w_brk;
      end

      if (w_note_upd) r_notes[w_note.idx] <= !w_brk;

      if (w_up_step && (r_octave < OCT_HI)) r_octave <= r_octave + 4'sd1;
      if (w_dn_step && (r_octave > OCT_LO)) r_octave <= r_octave - 4'sd1;

      if (w_arrow && (byte_data == CODE_LEFT))  r_flat  <= !w_brk;
      if (w_arrow && (byte_data == CODE_RIGHT)) r_sharp <= !w_brk;
    end
  end

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_ext   = r_key_ext;
  assign key_break = r_key_break;
  assign note_held = r_notes;
  assign octave    = r_octave;
  assign flat      = r_flat;
  assign sharp     = r_sharp;

endmodule
